gamepad_multi: RTL and testbench
================================

# gamepad_multi

Parametrised successor to the single-pad Genesis controller reader. It scans NUM_PADS Sega-style pads in parallel, once per frame, triggered by v_sync. It supports 3- and 6-button protocols, per-pad presence and type detection, frame-based debounce, and press/release event pulses. It sits beside TemporizadorEntradas, whose `Entradas` input is fed from pad 0's slice of `Saidas`.

## Interface
Parameters:
- NUM_PADS, 2: number of pads scanned in parallel; range 1–4.
- SIX_BUTTON, 1: 1 runs the 8-phase 6-button scan; 0 runs the 2-phase 3-button scan.
- SELECT_HALF_CYCLES, 500: clock cycles per Select phase, H (10 µs at 50 MHz); minimum 4.
- DEBOUNCE_FRAMES, 2: consecutive identical scans required before a commit; range 1–7.

Ports:
- Clock50  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- v_sync  in  1  frame sync from Interface; asynchronous to this block.
- Pino1, Pino2, Pino3, Pino4, Pino6, Pino9  in  NUM_PADS each  pad data pins, active low; bit k belongs to pad k.
- Select  out  1  drives all pads; idles high.
- Saidas  out  12*NUM_PADS  debounced buttons, active high. Pad k occupies [12k+11:12k] in this order: Up, Down, Left, Right, A, B, C, Start, X, Y, Z, Mode.
- Pressed  out  12*NUM_PADS  one-cycle pulse on each 0→1 commit.
- Released  out  12*NUM_PADS  one-cycle pulse on each 1→0 commit.
- Valid  out  1  one-cycle pulse at the end of every scan.
- Present  out  NUM_PADS  pad detected on the last scan.
- SixBtn  out  NUM_PADS  6-button pad detected on the last scan.
- Busy  out  1  high while a scan is in progress.

## Operation
- Every pin input passes through a 2-FF synchronizer. v_sync also passes through a 2-FF synchronizer and a rising-edge detector.
- FSM has three states: IDLE, SCAN, COMMIT.
- IDLE: Select=1. A v_sync rising edge moves the FSM to SCAN with phase p=0 and counter c=0.
- SCAN:
  - Select = ~p[0].
  - c counts 0..H-1. At c=H-1 the synchronized pins are sampled, c resets to 0, and p increments.
  - After the last phase (p=7 if SIX_BUTTON, else p=1) the FSM goes to COMMIT.
- Per-pad sampling, pins inverted to active high:
  - p0: Up=Pino1, Down=Pino2, Left=Pino3, Right=Pino4, B=Pino6, C=Pino9.
  - p1: A=Pino6, Start=Pino9. Present = (raw Pino3==0 && raw Pino4==0).
  - p5: SixBtn = SIX_BUTTON && raw Pino1..Pino4 all 0.
  - p6: Z=Pino1, Y=Pino2, X=Pino3, Mode=Pino4.
  - Phases p2, p3, p4 and p7 are not sampled.
- Forcing rules for the candidate vector:
  - If not Present, the whole 12-bit candidate is 0.
  - If not SixBtn, X, Y, Z and Mode are 0.
- COMMIT lasts 1 cycle, then returns to IDLE.
  - Per pad: if the candidate equals the previous scan's candidate, stable count = min(count+1, DEBOUNCE_FRAMES); otherwise count = 1.
  - When count reaches DEBOUNCE_FRAMES, Saidas takes the candidate; Pressed = new & ~old; Released = old & ~new.
  - Valid=1. Present and SixBtn update.
- A v_sync edge while in SCAN or COMMIT is dropped, not queued.

## Timing
- Reset values: Select=1, Busy=0, Valid=0. Saidas, Pressed, Released, Present, SixBtn, and all candidate and count registers are 0. FSM=IDLE.
- v_sync edge to SCAN entry: 3 cycles (2 synchronizer flops plus the edge detector).
- Scan length is P*H cycles (P=8 or 2), then 1 COMMIT cycle. Busy is high for exactly P*H+1 cycles.
- Select falls at SCAN entry+H and toggles every H cycles thereafter. It is high again on the cycle after COMMIT.
- Pin-to-sample latency is 2 cycles; pins must settle by c=H-3.
- Saidas, Pressed, Released, Present and SixBtn change only on the COMMIT→IDLE edge. Pulses last 1 cycle.
- Reset asserted mid-scan aborts the scan immediately: Select=1, all outputs 0, no Valid pulse.

## Test plan
- Test parameters: NUM_PADS=2, H=4, SIX_BUTTON=1, DEBOUNCE_FRAMES=2.
- Pad0 is a 6-button model holding A+Start and pad1 pins float high. Two v_sync edges → after the 2nd Valid, Saidas[11:0]=0x090, Present=2'b01, SixBtn=2'b01, Saidas[23:12]=0. Pressed[11:0]=0x090 for 1 cycle.
- Select trace, one scan → Select high 4 cycles, then 8 phases of 4 cycles alternating 1,0,…, first fall at SCAN entry+4. Busy high 33 cycles.
- Pad0 3-button model with Up held for 1 frame only → candidate changes but count=1, so there is no commit. Saidas stays 0 and Pressed stays 0.
- Pad1 6-button model releases X after a stable press → 2 scans later Released[20]=1 for 1 cycle and Saidas[20]=0.
- Second v_sync edge 10 cycles into a scan → ignored. Exactly one Valid pulse, and the next scan needs a fresh edge.
- Reset asserted during p3 → Select=1 the same cycle, Saidas=0, no Valid. The next v_sync starts a clean scan.

Source files
------------

// File: rtl/gamepad_multi.sv
// Parallel Sega 3/6-button pad reader: one scan per v_sync frame, per-pad presence
// and type detection, frame debounce and one-cycle press/release event pulses.
module gamepad_multi #(
  parameter int NUM_PADS           = 2,
  parameter int SIX_BUTTON         = 1,
  parameter int SELECT_HALF_CYCLES = 500,
  parameter int DEBOUNCE_FRAMES    = 2
) (
  input  logic                   Clock50,
  input  logic                   Reset,
  input  logic                   v_sync,
  input  logic [NUM_PADS-1:0]    Pino1,
  input  logic [NUM_PADS-1:0]    Pino2,
  input  logic [NUM_PADS-1:0]    Pino3,
  input  logic [NUM_PADS-1:0]    Pino4,
  input  logic [NUM_PADS-1:0]    Pino6,
  input  logic [NUM_PADS-1:0]    Pino9,
  output logic                   Select,
  output logic [12*NUM_PADS-1:0] Saidas,
  output logic [12*NUM_PADS-1:0] Pressed,
  output logic [12*NUM_PADS-1:0] Released,
  output logic                   Valid,
  output logic [NUM_PADS-1:0]    Present,
  output logic [NUM_PADS-1:0]    SixBtn,
  output logic                   Busy
);

  localparam int             CW         = (SELECT_HALF_CYCLES > 1) ? $clog2(SELECT_HALF_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST   = CW'(SELECT_HALF_CYCLES - 1);
  localparam logic [2:0]     LAST_PHASE = (SIX_BUTTON != 0) ? 3'd7 : 3'd1;
  localparam logic [2:0]     DB_MAX     = 3'(DEBOUNCE_FRAMES);
  localparam logic           SIX_EN     = (SIX_BUTTON != 0);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } state_t;

  state_t state, state_next;

  // Index 0..5 = Pino1, Pino2, Pino3, Pino4, Pino6, Pino9
  logic [5:0][NUM_PADS-1:0] pin_raw, pin_meta, pin_sync;
  logic                     vs_meta, vs_sync, vs_prev, vs_rise;

  logic [CW-1:0] cnt;
  logic [2:0]    phase;
  logic          phase_end;

  logic [NUM_PADS-1:0][11:0] cand_raw, cand, cand_prev;
  logic [NUM_PADS-1:0]       pres_scan, six_scan;
  logic [NUM_PADS-1:0][2:0]  stable_cnt, stable_next;

  assign pin_raw = {Pino9, Pino6, Pino4, Pino3, Pino2, Pino1};

  always_ff @(posedge Clock50 or posedge Reset) begin
    if (Reset) begin
      pin_meta <= '1;
      pin_sync <= '1;
      vs_meta  <= 1'b0;
      vs_sync  <= 1'b0;
      vs_prev  <= 1'b0;
    end else begin
      pin_meta <= pin_raw;
      pin_sync <= pin_meta;
      vs_meta  <= v_sync;
      vs_sync  <= vs_meta;
      vs_prev  <= vs_sync;
    end
  end

  assign vs_rise   = vs_sync & ~vs_prev;
  assign phase_end = (state == SCAN) && (cnt == CNT_LAST);

  always_ff @(posedge Clock50 or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Edges seen outside IDLE are simply ignored, so nothing is queued
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (vs_rise) state_next = SCAN;
      SCAN:    if (phase_end && (phase == LAST_PHASE)) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Select = 1'b1;
    Busy   = 1'b0;
    case (state)
      SCAN: begin
        Select = ~phase[0];
        Busy   = 1'b1;
      end
      COMMIT: begin
        Select = 1'b0;
        Busy   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock50 or posedge Reset) begin
    if (Reset) begin
      cnt   <= '0;
      phase <= 3'd0;
    end else if (state != SCAN) begin
      cnt   <= '0;
      phase <= 3'd0;
    end else if (phase_end) begin
      cnt   <= '0;
      phase <= phase + 3'd1;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

  // Presence and type flags are cleared at scan start because p5 never runs in 3-button mode
  always_ff @(posedge Clock50 or posedge Reset) begin
    if (Reset) begin
      cand_raw  <= '0;
      pres_scan <= '0;
      six_scan  <= '0;
    end else if ((state == IDLE) && vs_rise) begin
      pres_scan <= '0;
      six_scan  <= '0;
    end else if (phase_end) begin
      for (int k = 0; k < NUM_PADS; k++) begin
        case (phase)
          3'd0: begin
            cand_raw[k][0] <= ~pin_sync[0][k];
            cand_raw[k][1] <= ~pin_sync[1][k];
            cand_raw[k][2] <= ~pin_sync[2][k];
            cand_raw[k][3] <= ~pin_sync[3][k];
            cand_raw[k][5] <= ~pin_sync[4][k];
            cand_raw[k][6] <= ~pin_sync[5][k];
          end
          3'd1: begin
            cand_raw[k][4] <= ~pin_sync[4][k];
            cand_raw[k][7] <= ~pin_sync[5][k];
            pres_scan[k]   <= ~pin_sync[2][k] & ~pin_sync[3][k];
          end
          3'd5: begin
            six_scan[k] <= SIX_EN &
                           ~(pin_sync[0][k] | pin_sync[1][k] | pin_sync[2][k] | pin_sync[3][k]);
          end
          3'd6: begin
            cand_raw[k][10] <= ~pin_sync[0][k];
            cand_raw[k][9]  <= ~pin_sync[1][k];
            cand_raw[k][8]  <= ~pin_sync[2][k];
            cand_raw[k][11] <= ~pin_sync[3][k];
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    cand        = '0;
    stable_next = '0;
    for (int k = 0; k < NUM_PADS; k++) begin
      if (pres_scan[k])
        cand[k] = six_scan[k] ? cand_raw[k] : {4'b0000, cand_raw[k][7:0]};
      if (cand[k] != cand_prev[k])
        stable_next[k] = 3'd1;
      else if (stable_cnt[k] >= DB_MAX)
        stable_next[k] = DB_MAX;
      else
        stable_next[k] = stable_cnt[k] + 3'd1;
    end
  end

  // All visible state moves on the COMMIT->IDLE edge; pulses self-clear a cycle later
  always_ff @(posedge Clock50 or posedge Reset) begin
    if (Reset) begin
      cand_prev  <= '0;
      stable_cnt <= '0;
      Saidas     <= '0;
      Pressed    <= '0;
      Released   <= '0;
      Valid      <= 1'b0;
      Present    <= '0;
      SixBtn     <= '0;
    end else begin
      Pressed  <= '0;
      Released <= '0;
      Valid    <= 1'b0;
      if (state == COMMIT) begin
        Valid   <= 1'b1;
        Present <= pres_scan;
        SixBtn  <= six_scan;
        for (int k = 0; k < NUM_PADS; k++) begin
          cand_prev[k]  <= cand[k];
          stable_cnt[k] <= stable_next[k];
          if (stable_next[k] == DB_MAX) begin
            Saidas[12*k +: 12]   <= cand[k];
            Pressed[12*k +: 12]  <= cand[k] & ~Saidas[12*k +: 12];
            Released[12*k +: 12] <= Saidas[12*k +: 12] & ~cand[k];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gamepad_multi.sv
// Bench for gamepad_multi: behavioural Sega pad models on both ports, a vector
// table of button patterns, and directed multi-cycle corner-case sequences.
module tb_gamepad_multi;

  localparam int NP = 2;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          v_sync;
  logic [NP-1:0] pino1, pino2, pino3, pino4, pino6, pino9;
  logic          sel, valid, busy;
  logic [23:0]   saidas, pressed, released;
  logic [1:0]    present, six_btn;

  int errors = 0;
  int checks = 0;

  // Pad model: type 0 = unplugged (floating high), 1 = 3-button, 2 = 6-button
  logic [1:0]  pad_type [NP];
  logic [11:0] pad_btn  [NP];
  int          fall_cnt = 0;
  int          hi_cnt   = 0;
  logic        sel_prev = 1'b1;

  typedef struct {
    logic [1:0]  t0;
    logic [11:0] b0;
    logic [1:0]  t1;
    logic [11:0] b1;
    logic [23:0] exp_out;
    logic [23:0] exp_pr;
    logic [23:0] exp_rl;
    logic [1:0]  exp_pres;
    logic [1:0]  exp_six;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  gamepad_multi #(
    .NUM_PADS(NP),
    .SIX_BUTTON(1),
    .SELECT_HALF_CYCLES(H),
    .DEBOUNCE_FRAMES(2)
  ) dut (
    .Clock50(clk),
    .Reset(rst),
    .v_sync(v_sync),
    .Pino1(pino1),
    .Pino2(pino2),
    .Pino3(pino3),
    .Pino4(pino4),
    .Pino6(pino6),
    .Pino9(pino9),
    .Select(sel),
    .Saidas(saidas),
    .Pressed(pressed),
    .Released(released),
    .Valid(valid),
    .Present(present),
    .SixBtn(six_btn),
    .Busy(busy)
  );

  // Returns {Pino9, Pino6, Pino4, Pino3, Pino2, Pino1}, active low
  function automatic logic [5:0] pad_pins(input logic [1:0] typ, input logic [11:0] b,
                                          input logic s, input int f);
    logic six;
    six = (typ == 2'd2);
    if (typ == 2'd0) return 6'h3F;
    if (s) begin
      if (six && f == 3) return {~b[6], ~b[5], ~b[11], ~b[8], ~b[9], ~b[10]};
      return {~b[6], ~b[5], ~b[3], ~b[2], ~b[1], ~b[0]};
    end
    if (six && f == 3) return {~b[7], ~b[4], 4'b0000};
    if (six && f >= 4) return {~b[7], ~b[4], 4'b1111};
    return {~b[7], ~b[4], 2'b00, ~b[1], ~b[0]};
  endfunction

  // A long high Select resets the pad's internal phase counter, as on real hardware
  always @(negedge clk) begin
    if (sel && hi_cnt >= 6)       fall_cnt <= 0;
    else if (sel_prev && !sel)    fall_cnt <= fall_cnt + 1;
    hi_cnt   <= sel ? hi_cnt + 1 : 0;
    sel_prev <= sel;
  end

  for (genvar g = 0; g < NP; g++) begin : g_pad
    assign {pino9[g], pino6[g], pino4[g], pino3[g], pino2[g], pino1[g]} =
      pad_pins(pad_type[g], pad_btn[g], sel, fall_cnt);
  end

  task automatic applyStimulus(input logic [1:0] t0, input logic [11:0] b0,
                               input logic [1:0] t1, input logic [11:0] b1);
    pad_type[0] = t0;
    pad_btn[0]  = b0;
    pad_type[1] = t1;
    pad_btn[1]  = b1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic runScan();
    int n;
    repeat (10) @(negedge clk);
    v_sync = 1'b1;
    repeat (4) @(negedge clk);
    v_sync = 1'b0;
    n = 0;
    while (!valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scan_valid", {31'd0, valid}, 32'd1);
  endtask

  task automatic startScan();
    int n;
    repeat (10) @(negedge clk);
    v_sync = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < 20);
    v_sync = 1'b0;
    checkOutput("scan_start", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    int n, sel_bad, vcount, bcount;
    logic exp_sel;

    vecs[0] = '{2'd2, 12'h090, 2'd0, 12'h000, 24'h000090, 24'h000090, 24'h000000, 2'b01, 2'b01};
    vecs[1] = '{2'd1, 12'h141, 2'd2, 12'hA20, 24'hA20041, 24'hA20041, 24'h000090, 2'b11, 2'b10};
    vecs[2] = '{2'd2, 12'hFFF, 2'd1, 12'h088, 24'h088FFF, 24'h088FBE, 24'hA20000, 2'b11, 2'b01};
    vecs[3] = '{2'd0, 12'h000, 2'd0, 12'h000, 24'h000000, 24'h000000, 24'h088FFF, 2'b00, 2'b00};
    vecs[4] = '{2'd2, 12'h000, 2'd2, 12'h402, 24'h402000, 24'h402000, 24'h000000, 2'b11, 2'b11};

    applyStimulus(2'd0, 12'h000, 2'd0, 12'h000);
    v_sync = 1'b0;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_select", {31'd0, sel}, 32'd1);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_valid", {31'd0, valid}, 32'd0);
    checkOutput("reset_saidas", {8'd0, saidas}, 32'd0);
    checkOutput("reset_present", {30'd0, present}, 32'd0);
    checkOutput("reset_sixbtn", {30'd0, six_btn}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Each row is held for two frames so it always commits by the second Valid
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].t0, vecs[i].b0, vecs[i].t1, vecs[i].b1);
      runScan();
      runScan();
      checkOutput($sformatf("vec%0d_saidas", i), {8'd0, saidas}, {8'd0, vecs[i].exp_out});
      checkOutput($sformatf("vec%0d_pressed", i), {8'd0, pressed}, {8'd0, vecs[i].exp_pr});
      checkOutput($sformatf("vec%0d_released", i), {8'd0, released}, {8'd0, vecs[i].exp_rl});
      checkOutput($sformatf("vec%0d_present", i), {30'd0, present}, {30'd0, vecs[i].exp_pres});
      checkOutput($sformatf("vec%0d_sixbtn", i), {30'd0, six_btn}, {30'd0, vecs[i].exp_six});
      if (i == 0) begin
        @(negedge clk);
        checkOutput("pressed_pulse_end", {8'd0, pressed}, 32'd0);
        checkOutput("valid_pulse_end", {31'd0, valid}, 32'd0);
      end
    end

    // v_sync latency, Select waveform and Busy length over one scan
    repeat (10) @(negedge clk);
    v_sync = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < 20);
    v_sync = 1'b0;
    checkOutput("vsync_to_scan", n, 32'd3);
    sel_bad = 0;
    n = 0;
    while (busy && n < 100) begin
      exp_sel = (n < 32) ? ~n[2] : 1'b0;
      if (sel !== exp_sel) sel_bad++;
      @(negedge clk);
      n++;
    end
    checkOutput("busy_cycles", n, 32'd33);
    checkOutput("select_trace_bad_cycles", sel_bad, 32'd0);
    checkOutput("select_idle_after", {31'd0, sel}, 32'd1);
    checkOutput("valid_after_scan", {31'd0, valid}, 32'd1);

    // A single-frame glitch must not commit
    doReset();
    applyStimulus(2'd1, 12'h001, 2'd0, 12'h000);
    runScan();
    checkOutput("glitch1_saidas", {8'd0, saidas}, 32'd0);
    checkOutput("glitch1_pressed", {8'd0, pressed}, 32'd0);
    checkOutput("glitch1_present", {30'd0, present}, 32'd1);
    applyStimulus(2'd1, 12'h000, 2'd0, 12'h000);
    runScan();
    checkOutput("glitch2_saidas", {8'd0, saidas}, 32'd0);
    checkOutput("glitch2_pressed", {8'd0, pressed}, 32'd0);

    // Pad1 X press then release
    doReset();
    applyStimulus(2'd0, 12'h000, 2'd2, 12'h100);
    runScan();
    runScan();
    checkOutput("x_press_saidas", {8'd0, saidas}, 32'h100000);
    checkOutput("x_press_pulse", {8'd0, pressed}, 32'h100000);
    applyStimulus(2'd0, 12'h000, 2'd2, 12'h000);
    runScan();
    checkOutput("x_rel1_saidas", {8'd0, saidas}, 32'h100000);
    checkOutput("x_rel1_released", {8'd0, released}, 32'd0);
    runScan();
    checkOutput("x_rel2_saidas", {8'd0, saidas}, 32'd0);
    checkOutput("x_rel2_released", {8'd0, released}, 32'h100000);
    @(negedge clk);
    checkOutput("x_rel_pulse_end", {8'd0, released}, 32'd0);

    // A second edge during a scan is dropped
    doReset();
    applyStimulus(2'd0, 12'h000, 2'd0, 12'h000);
    startScan();
    repeat (10) @(negedge clk);
    v_sync = 1'b1;
    repeat (3) @(negedge clk);
    v_sync = 1'b0;
    vcount = 0;
    repeat (80) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    checkOutput("dropped_edge_valids", vcount, 32'd1);
    bcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) bcount++;
    end
    checkOutput("no_queued_scan", bcount, 32'd0);
    runScan();

    // Reset in phase 3 aborts the scan
    applyStimulus(2'd2, 12'h090, 2'd0, 12'h000);
    runScan();
    runScan();
    checkOutput("pre_abort_saidas", {8'd0, saidas}, 32'h000090);
    startScan();
    repeat (13) @(negedge clk);
    checkOutput("select_p3_low", {31'd0, sel}, 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("abort_select", {31'd0, sel}, 32'd1);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_saidas", {8'd0, saidas}, 32'd0);
    checkOutput("abort_present", {30'd0, present}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    repeat (60) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    checkOutput("abort_no_valid", vcount, 32'd0);
    runScan();
    checkOutput("post_abort_present", {30'd0, present}, 32'd1);
    checkOutput("post_abort_saidas", {8'd0, saidas}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
